// File: rtl/interval_pkg.sv
// Shared types and sizes for the interval classifier / decoder pair.
// The fp16 payload is treated as an opaque bit pattern throughout.
package interval_pkg;

  localparam int WIDTH = 16;
  localparam int NUM   = 8;
  localparam int IDX_W = $clog2(NUM);

  typedef logic [15:0]    fp16_t;
  typedef logic [NUM-1:0] interval_t;

endpackage

// File: rtl/interval_decode_onehot_to_idx.sv
// Combinational lowest-set-bit encoder for a one-hot interval code.
// An all-zero code yields idx 0 and err 1; a multi-hot code yields the
// lowest set bit and err 1.
module onehot_to_idx #(
  parameter int NUM   = 8,
  parameter int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [NUM-1:0]   code_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             err_o
);

  localparam logic [NUM-1:0] ONE = {{(NUM-1){1'b0}}, 1'b1};

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (code_i[k]) idx_o = IDX_W'(k);
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means multi-hot.
  always_comb begin
    err_o = (code_i == '0) || ((code_i & (code_i - ONE)) != '0);
  end

endmodule

// File: rtl/interval_decode.sv
// interval_decode: one-hot interval code -> programmable fp16 representative.
// Two-stage valid/ready pipeline (encode, then table lookup) with
// back-pressure and full throughput.
// Optional build macro INTERVAL_ERR_CNT_EN adds err_cnt_o, a saturating count
// of accepted codes that were not one-hot.
module interval_decode #(
  parameter int WIDTH = interval_pkg::WIDTH,
  parameter int NUM   = interval_pkg::NUM
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  tbl_we_i,
  input  logic [((NUM > 1) ? $clog2(NUM) : 1)-1:0] tbl_addr_i,
  input  logic [WIDTH-1:0]                      tbl_data_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [NUM-1:0]                        interval_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [WIDTH-1:0]                      value_o,
  output logic                                  err_o
`ifdef INTERVAL_ERR_CNT_EN
  ,
  output logic [15:0]                           err_cnt_o
`endif
);

  import interval_pkg::*;

  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

  logic [WIDTH-1:0] tbl_q [NUM];
  logic [WIDTH-1:0] tbl_d [NUM];

  logic             s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0] s1_idx_q,   s1_idx_d;
  logic             s1_err_q,   s1_err_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_val_q,   s2_val_d;
  logic             s2_err_q,   s2_err_d;

  logic             s1_adv, s2_adv;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_err;

  onehot_to_idx #(
    .NUM   (NUM),
    .IDX_W (IDX_W)
  ) u_enc (
    .code_i (interval_i),
    .idx_o  (enc_idx),
    .err_o  (enc_err)
  );

  // Ready chain: a stage may load when it is empty or its consumer drains it.
  always_comb begin
    s2_adv = !s2_valid_q || out_ready_i;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid_q;
  assign value_o     = s2_val_q;
  assign err_o       = s2_err_q;

  // Table write; matching by equality drops out-of-range addresses for free.
  always_comb begin
    tbl_d = tbl_q;
    for (int k = 0; k < NUM; k++) begin
      if (tbl_we_i && (tbl_addr_i == IDX_W'(k))) tbl_d[k] = tbl_data_i;
    end
  end

  // Stage 1 captures the encoded code on an input transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s1_err_d   = s1_err_q;
    if (s1_adv) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_idx_d = enc_idx;
        s1_err_d = enc_err;
      end
    end
  end

  // Stage 2 reads the pre-write table contents, so a same-cycle write is
  // seen only by later lookups. Data holds across bubbles and stalls.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_val_d   = s2_val_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_val_d = tbl_q[s1_idx_q];
        s2_err_d = s1_err_q;
      end
    end
  end

  // Pipeline and table registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM; k++) tbl_q[k] <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_val_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      tbl_q      <= tbl_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_val_q   <= s2_val_d;
      s2_err_q   <= s2_err_d;
    end
  end

`ifdef INTERVAL_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count bad codes as they are accepted, sticking at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid_i && s1_adv && enc_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_interval_decode.sv
// Self-checking bench for interval_decode: directed steps plus a random
// phase, compared against a queue-based reference model. Build with
// INTERVAL_ERR_CNT_EN defined to also exercise the error counter.
module tb_interval_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_we;
  logic [2:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        in_valid;
  logic        in_ready_o;
  logic [7:0]  interval;
  logic        out_valid_o;
  logic        out_ready;
  logic [15:0] value_o;
  logic        err_o;
`ifdef INTERVAL_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  always #5 clk = ~clk;

  interval_decode dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tbl_we_i    (tbl_we),
    .tbl_addr_i  (tbl_addr),
    .tbl_data_i  (tbl_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .interval_i  (interval),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .value_o     (value_o),
    .err_o       (err_o)
`ifdef INTERVAL_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt_o)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  logic [16:0] expq [$];
  logic [15:0] shadow [8];
  int          cnt_model;
  int          cyc_n;
  int          first_out, last_out, out_n;
  logic        in_x;
  logic        stall_prev;
  logic [16:0] stall_val;
  logic        saw_nr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: representative of the lowest set bit, err unless exactly one bit set.
  function automatic logic [16:0] ref_out(input logic [7:0] c);
    int idx;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if (c[k]) begin
        idx = k;
        break;
      end
    end
    return {($countones(c) != 1), shadow[idx]};
  endfunction

  // One clock cycle: sample/check just before the edge, then update the model.
  task automatic tick();
    logic ix, ox;
    logic [16:0] e;
    #1;
    if (!rst) begin
      chk("in_ready", 32'(in_ready_o), 32'((expq.size() < 2) || out_ready));
`ifdef INTERVAL_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt_o), 32'(cnt_model));
`endif
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_data", 32'({err_o, value_o}), 32'(stall_val));
      end
    end
    ix = in_valid & in_ready_o;
    ox = out_valid_o & out_ready;
    if (!rst) begin
      if (out_valid_o && expq.size() == 0) begin
        chk("spurious_out", 32'(out_valid_o), 32'd0);
      end else if (ox) begin
        e = expq.pop_front();
        chk("out_data", 32'({err_o, value_o}), 32'(e));
        out_n++;
        if (first_out < 0) first_out = cyc_n;
        last_out = cyc_n;
      end
      if (ix) begin
        e = ref_out(interval);
        expq.push_back(e);
        if (e[16] && cnt_model < 65535) cnt_model++;
      end
      stall_prev = out_valid_o & !out_ready;
      stall_val  = {err_o, value_o};
      if (!in_ready_o) saw_nr = 1'b1;
    end
    in_x = ix;
    @(posedge clk);
    if (rst) begin
      expq.delete();
      for (int k = 0; k < 8; k++) shadow[k] = 16'h0000;
      cnt_model  = 0;
      stall_prev = 1'b0;
    end else if (tbl_we) begin
      shadow[tbl_addr] = tbl_data;
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    tbl_we   = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    tbl_we   = 1'b1;
    tbl_addr = a;
    tbl_data = d;
    tick();
    tbl_we   = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, sent;
    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    in_valid = 1'b0; interval = '0; out_ready = 1'b1;
    cnt_model = 0; cyc_n = 0; first_out = -1; last_out = 0; out_n = 0;
    stall_prev = 1'b0; stall_val = '0; saw_nr = 1'b0; in_x = 1'b0;
    for (int k = 0; k < 8; k++) shadow[k] = 16'h0000;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_value", 32'(value_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);

    // Program table and stream all eight one-hot codes back-to-back.
    for (int k = 0; k < 8; k++) wr(3'(k), 16'h3C00 + 16'(k));
    first_out = -1; out_n = 0; t0 = cyc_n;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      interval = 8'(1 << k);
      tick();
      chk("basic_accept", 32'(in_x), 32'd1);
    end
    idle(4);
    chk("latency", 32'(first_out - t0), 32'd2);
    chk("basic_count", 32'(out_n), 32'd8);
    chk("basic_back2back", 32'(last_out - first_out), 32'd7);

    // Invalid codes: zero and multi-hot.
    in_valid = 1'b1; interval = 8'h00; tick();
    interval = 8'h14; tick();
    idle(3);

    // Back-pressure: 10 codes with a 5-cycle output stall mid-stream.
    sent = 0; saw_nr = 1'b0; out_n = 0;
    for (int c = 0; c < 40 && (sent < 10 || expq.size() > 0); c++) begin
      in_valid  = (sent < 10);
      interval  = 8'(1 << (sent % 8));
      out_ready = !(c >= 4 && c < 9);
      tick();
      if (in_x) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd10);
    chk("bp_received", 32'(out_n), 32'd10);
    chk("bp_ready_dropped", 32'(saw_nr), 32'd1);
    chk("bp_drained", 32'(expq.size()), 32'd0);

    // Write/read collision on entry 3.
    wr(3'd3, 16'h4200);
    idle(1);
    in_valid = 1'b1; interval = 8'h08; tick();
    in_valid = 1'b0;
    wr(3'd3, 16'h4500);
    in_valid = 1'b1; interval = 8'h08; tick();
    idle(3);

    // Random phase over a random table.
    for (int k = 0; k < 8; k++) wr(3'(k), 16'($urandom));
    idle(1);
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       interval = 8'h00;
        1:       interval = 8'($urandom);
        default: interval = 8'(1 << $urandom_range(0, 7));
      endcase
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(6);
    chk("rand_drained", 32'(expq.size()), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; interval = 8'h02; tick();
    interval = 8'h04; tick();
    in_valid = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_value", 32'(value_o), 32'd0);
    idle(2);
    chk("mid_rst_no_partial", 32'(out_n), 32'(out_n));
    in_valid = 1'b1; interval = 8'h10; tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("post_rst_valid", 32'(out_valid_o), 32'd1);
    chk("post_rst_value", 32'(value_o), 32'd0);
    idle(2);

`ifdef INTERVAL_ERR_CNT_EN
    // Saturation: a long stream of all-zero codes.
    out_ready = 1'b1; in_valid = 1'b1; interval = 8'h00;
    for (int c = 0; c < 65540; c++) tick();
    idle(3);
    chk("err_cnt_sat", 32'(err_cnt_o), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
